// File: rtl/dbus_pkg.sv
// Shared types for the data-bus responder: posted-write entry, FSM states, wait counter width.
package dbus_pkg;

  // Word addresses are carried at full 30-bit width; unused upper bits trim away.
  localparam int unsigned WordAddrW = 30;
  localparam int unsigned WaitCntW  = 4;

  typedef struct packed {
    logic [WordAddrW-1:0] addr;
    logic [31:0]          wdata;
    logic [3:0]           wstrb;
  } wb_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StRead,
    StResp
  } dbus_state_e;

endpackage

// File: rtl/dbus_resp_if.sv
// Load/store bus between the core and the data-bus responder.
interface dbus_resp_if #(
  parameter int unsigned ADDR_W = 12
) ();

  logic              wr_dbus_en;
  logic              rd_dbus_en;
  logic [ADDR_W-1:0] dbus_addr;
  logic [31:0]       dbus_wdata;
  logic [3:0]        dbus_wstrb;
  logic              dbus_busy;
  logic [31:0]       dbus_rdata;
  logic              dbus_rvalid;
  logic              dbus_err;

  modport master (
    output wr_dbus_en, rd_dbus_en, dbus_addr, dbus_wdata, dbus_wstrb,
    input  dbus_busy, dbus_rdata, dbus_rvalid, dbus_err
  );

  modport slave (
    input  wr_dbus_en, rd_dbus_en, dbus_addr, dbus_wdata, dbus_wstrb,
    output dbus_busy, dbus_rdata, dbus_rvalid, dbus_err
  );

endinterface

// File: rtl/dbus_wbuf.sv
// In-order posted-write buffer: synchronous FIFO of wb_entry_t with wrap-bit pointers.
module dbus_wbuf
  import dbus_pkg::*;
#(
  parameter int unsigned WB_DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  wb_entry_t data_i,
  input  logic      pop_i,
  output wb_entry_t data_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned PtrW = $clog2(WB_DEPTH);

  wb_entry_t       mem_q [WB_DEPTH];
  logic [PtrW:0]   wr_ptr_q, rd_ptr_q;
  logic            do_push, do_pop;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign data_o  = mem_q[rd_ptr_q[PtrW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (PtrW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (PtrW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= data_i;
  end

endmodule

// File: rtl/dbus_resp.sv
// Data-bus responder: posted writes, ordered reads, wait-stated word array.
// Optional DBUS_RESP_ERR_EN: out-of-range accesses are dropped/zeroed and flag a sticky error.
module dbus_resp
  import dbus_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned MEM_WORDS = 256,
  parameter int unsigned WB_DEPTH  = 4,
  parameter int unsigned WAIT      = 1
) (
  input logic        clk,
  input logic        rst_n,
  dbus_resp_if.slave bus
);

  localparam int unsigned IdxW = $clog2(MEM_WORDS);

  dbus_state_e          state_q, state_d;
  logic [WaitCntW-1:0]  cnt_q, cnt_d;
  wb_entry_t            cur_q, cur_d;
  logic                 rd_pend_v_q, rd_pend_v_d;
  logic [WordAddrW-1:0] rd_addr_q, rd_addr_d;
  logic [31:0]          rdata_q, rdata_d;

  logic                 busy, wr_acc, rd_acc;
  logic                 wb_full, wb_empty, wb_pop;
  wb_entry_t            wb_head, push_entry;
  logic                 mem_we, mem_wr_ok, rd_load;
  logic [31:0]          rd_word;
  logic [31:0]          mem_q [MEM_WORDS];
  logic                 unused_bits;

  assign busy   = wb_full || rd_pend_v_q || (state_q == StRead) || (state_q == StResp);
  assign wr_acc = bus.wr_dbus_en && !busy;
  assign rd_acc = bus.rd_dbus_en && !busy;

  assign push_entry.addr  = WordAddrW'(bus.dbus_addr[ADDR_W-1:2]);
  assign push_entry.wdata = bus.dbus_wdata;
  assign push_entry.wstrb = bus.dbus_wstrb;

  dbus_wbuf #(
    .WB_DEPTH(WB_DEPTH)
  ) u_wbuf (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (wr_acc),
    .data_i (push_entry),
    .pop_i  (wb_pop),
    .data_o (wb_head),
    .full_o (wb_full),
    .empty_o(wb_empty)
  );

  // Buffered writes always drain before a pending read, which keeps reads ordered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    wb_pop  = 1'b0;
    mem_we  = 1'b0;
    rd_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!wb_empty) begin
          wb_pop  = 1'b1;
          cur_d   = wb_head;
          cnt_d   = WaitCntW'(WAIT);
          state_d = StWrite;
        end else if (rd_pend_v_q) begin
          cnt_d   = WaitCntW'(WAIT);
          state_d = StRead;
        end
      end
      StWrite: begin
        if (cnt_q == '0) begin
          mem_we  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - WaitCntW'(1);
        end
      end
      StRead: begin
        if (cnt_q == '0) begin
          rd_load = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - WaitCntW'(1);
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_pend_v_d = rd_pend_v_q;
    rd_addr_d   = rd_addr_q;
    if (rd_acc) begin
      rd_pend_v_d = 1'b1;
      rd_addr_d   = WordAddrW'(bus.dbus_addr[ADDR_W-1:2]);
    end else if (rd_load) begin
      rd_pend_v_d = 1'b0;
    end
    rdata_d = rd_load ? rd_word : rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cur_q       <= '0;
      rd_pend_v_q <= 1'b0;
      rd_addr_q   <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_q       <= cur_d;
      rd_pend_v_q <= rd_pend_v_d;
      rd_addr_q   <= rd_addr_d;
      rdata_q     <= rdata_d;
    end
  end

`ifdef DBUS_RESP_ERR_EN
  logic wr_oob, rd_oob;
  logic err_q, err_d;

  assign wr_oob    = cur_q.addr >= WordAddrW'(MEM_WORDS);
  assign rd_oob    = rd_addr_q >= WordAddrW'(MEM_WORDS);
  assign mem_wr_ok = mem_we && !wr_oob;
  assign rd_word   = rd_oob ? 32'h0 : mem_q[rd_addr_q[IdxW-1:0]];
  assign err_d     = err_q || (mem_we && wr_oob) || (rd_load && rd_oob);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign bus.dbus_err = err_q;
`else
  // Upper word-address bits alias onto the array.
  assign mem_wr_ok    = mem_we;
  assign rd_word      = mem_q[rd_addr_q[IdxW-1:0]];
  assign bus.dbus_err = 1'b0;
`endif

  // Array deliberately has no reset so committed data survives a core reset.
  always_ff @(posedge clk) begin
    if (mem_wr_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_q.wstrb[b]) mem_q[cur_q.addr[IdxW-1:0]][8*b +: 8] <= cur_q.wdata[8*b +: 8];
      end
    end
  end

  assign bus.dbus_busy   = busy;
  assign bus.dbus_rdata  = rdata_q;
  assign bus.dbus_rvalid = (state_q == StResp);

  assign unused_bits = ^{bus.dbus_addr[1:0], cur_q.addr[WordAddrW-1:IdxW],
                         rd_addr_q[WordAddrW-1:IdxW]};

endmodule

// File: tb/tb_dbus_resp.sv
// Scoreboard bench for dbus_resp: byte-level memory model, expected reads queued at acceptance.
module tb_dbus_resp;

  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned MEM_WORDS = 256;
  localparam int unsigned WB_DEPTH  = 4;
  localparam int unsigned WAIT      = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dbus_resp_if #(.ADDR_W(ADDR_W)) bus ();

  dbus_resp #(
    .ADDR_W   (ADDR_W),
    .MEM_WORDS(MEM_WORDS),
    .WB_DEPTH (WB_DEPTH),
    .WAIT     (WAIT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] mdl [MEM_WORDS];
  logic [31:0] exp_q [$];
  logic        exp_err = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic mdl_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
    int word;
    word = int'(addr >> 2);
`ifdef DBUS_RESP_ERR_EN
    if (word >= MEM_WORDS) begin
      exp_err = 1'b1;
      return;
    end
`endif
    word = word % MEM_WORDS;
    for (int b = 0; b < 4; b++) if (strb[b]) mdl[word][8*b +: 8] = data[8*b +: 8];
  endtask

  function automatic logic [31:0] mdl_read(input logic [ADDR_W-1:0] addr);
    int word;
    word = int'(addr >> 2);
`ifdef DBUS_RESP_ERR_EN
    if (word >= MEM_WORDS) begin
      exp_err = 1'b1;
      return 32'h0;
    end
`endif
    return mdl[word % MEM_WORDS];
  endfunction

  // Monitor: every response must match the oldest outstanding expected read.
  always @(negedge clk) begin
    if (rst_n && bus.dbus_rvalid) begin
      if (exp_q.size() == 0) check("unexpected_rvalid", 32'd1, 32'd0);
      else check("rdata", bus.dbus_rdata, exp_q.pop_front());
    end
  end

  task automatic idle_inputs();
    bus.wr_dbus_en = 1'b0;
    bus.rd_dbus_en = 1'b0;
  endtask

  task automatic issue(input bit wr, input bit rd, input logic [ADDR_W-1:0] addr,
                       input logic [31:0] data, input logic [3:0] strb, output bit acc);
    @(negedge clk);
    bus.wr_dbus_en = wr;
    bus.rd_dbus_en = rd;
    bus.dbus_addr  = addr;
    bus.dbus_wdata = data;
    bus.dbus_wstrb = strb;
    acc = !bus.dbus_busy;
    if (acc) begin
      if (wr) mdl_write(addr, data, strb);
      if (rd) exp_q.push_back(mdl_read(addr));
    end
    @(posedge clk);
    #1 idle_inputs();
  endtask

  task automatic issue_retry(input bit wr, input bit rd, input logic [ADDR_W-1:0] addr,
                             input logic [31:0] data, input logic [3:0] strb);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 100 && !acc; t++) issue(wr, rd, addr, data, strb, acc);
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || bus.dbus_busy) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 2000) check("drain_timeout", 32'd0, 32'd1);
    repeat (WB_DEPTH * (WAIT + 2) + 4) @(negedge clk);
  endtask

  // Read with empty buffer and idle responder: rvalid sampled WAIT+3 negedges after acceptance.
  task automatic timed_read(input logic [ADDR_W-1:0] addr, input string name);
    int lat;
    lat = 0;
    @(negedge clk);
    bus.rd_dbus_en = 1'b1;
    bus.wr_dbus_en = 1'b0;
    bus.dbus_addr  = addr;
    check({name, "_accept"}, {31'd0, !bus.dbus_busy}, 32'd1);
    exp_q.push_back(mdl_read(addr));
    @(posedge clk);
    #1 idle_inputs();
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.dbus_rvalid) begin
        lat = k;
        break;
      end
    end
    check({name, "_latency"}, lat, WAIT + 3);
    @(negedge clk);
    check({name, "_pulse"}, {31'd0, bus.dbus_rvalid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit          acc, saw_busy;
    int          sent, guard;
    logic [31:0] old_word, burst_data [7];

    idle_inputs();
    bus.dbus_addr  = '0;
    bus.dbus_wdata = '0;
    bus.dbus_wstrb = '0;

    #2 rst_n = 1'b0;
    #20;
    check("rst_busy",   {31'd0, bus.dbus_busy},   32'd0);
    check("rst_rdata",  bus.dbus_rdata,           32'd0);
    check("rst_rvalid", {31'd0, bus.dbus_rvalid}, 32'd0);
    check("rst_err",    {31'd0, bus.dbus_err},    32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Give every word the random phase and directed reads touch a defined value.
    for (int w = 0; w < 16; w++) issue_retry(1, 0, ADDR_W'(w * 4), $urandom, 4'hF);
    issue_retry(1, 0, 12'h3F0, 32'h0123_4567, 4'hF);
    drain();

    issue_retry(1, 0, 12'h100, 32'hDEAD_BEEF, 4'hF);
    drain();
    timed_read(12'h100, "basic_read");

    issue_retry(1, 0, 12'h020, 32'h1122_3344, 4'hF);
    issue_retry(1, 0, 12'h020, 32'hAABB_CCDD, 4'b0101);
    issue_retry(0, 1, 12'h020, 32'h0, 4'h0);
    drain();

    // Burst of posted writes; requests offered while busy carry junk and must be dropped.
    sent = 0;
    guard = 0;
    saw_busy = 1'b0;
    for (int i = 0; i < 7; i++) burst_data[i] = $urandom;
    while (sent < 7 && guard < 200) begin
      @(negedge clk);
      guard++;
      bus.wr_dbus_en = 1'b1;
      bus.dbus_wstrb = 4'hF;
      if (bus.dbus_busy) begin
        saw_busy       = 1'b1;
        bus.dbus_addr  = 12'h3F0;
        bus.dbus_wdata = 32'hBAD0_0000 | guard;
      end else begin
        bus.dbus_addr  = ADDR_W'(12'h200 + sent * 4);
        bus.dbus_wdata = burst_data[sent];
        mdl_write(bus.dbus_addr, burst_data[sent], 4'hF);
        sent++;
      end
      @(posedge clk);
      #1 idle_inputs();
    end
    check("burst_saw_busy", {31'd0, saw_busy}, 32'd1);
    check("burst_sent", sent, 7);
    for (int i = 0; i < 7; i++) issue_retry(0, 1, ADDR_W'(12'h200 + i * 4), 32'h0, 4'h0);
    issue_retry(0, 1, 12'h3F0, 32'h0, 4'h0);
    drain();

    issue_retry(1, 1, 12'h040, 32'h0000_0005, 4'hF);
    drain();

    issue_retry(1, 0, 12'h800, 32'hCAFE_F00D, 4'hF);
    issue_retry(0, 1, 12'h000, 32'h0, 4'h0);
    issue_retry(0, 1, 12'h800, 32'h0, 4'h0);
    drain();
    check("err_after_alias", {31'd0, bus.dbus_err}, {31'd0, exp_err});

    // Reset while a write is in its wait states: write lost, array keeps the old word.
    old_word = mdl[4];
    issue(1, 0, 12'h010, 32'hFFFF_0000, 4'hF, acc);
    check("rstw_accept", {31'd0, acc}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    mdl[4] = old_word;
    exp_err = 1'b0;
    #1;
    check("rstw_busy",   {31'd0, bus.dbus_busy},   32'd0);
    check("rstw_rdata",  bus.dbus_rdata,           32'd0);
    check("rstw_rvalid", {31'd0, bus.dbus_rvalid}, 32'd0);
    check("rstw_err",    {31'd0, bus.dbus_err},    32'd0);
    @(negedge clk) rst_n = 1'b1;
    timed_read(12'h010, "post_reset_read");
    drain();

    for (int i = 0; i < 400; i++) begin
      int          op, word;
      logic [11:0] a;
      op   = $urandom_range(0, 3);
      word = $urandom_range(0, 15) + 256 * $urandom_range(0, 3);
      a    = 12'(word * 4 + $urandom_range(0, 3));
      issue(op[0], op[1], a, $urandom, 4'($urandom_range(0, 15)), acc);
    end
    drain();

    check("final_queue_empty", exp_q.size(), 0);
    check("final_err", {31'd0, bus.dbus_err}, {31'd0, exp_err});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
